// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - SOF/LEN/payload/CHK frame parser replaying good payloads as a ready/valid stream
module uart_frame_parser #(
  parameter logic [7:0] SOF            = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       err_len,
  output logic       err_chk,
  output logic       err_timeout,
  output logic       err_overrun
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {HUNT, GET_LEN, GET_PAY, GET_CHK, EMIT} state_t;

  state_t         state, state_n;
  logic           rx_prev;
  logic [7:0]     len, idx, rd_idx, acc;
  logic [TW-1:0]  tmo_cnt;
  logic [7:0]     buf_mem [2**IW];

  logic byte_ev, in_frame, timed_out;
  logic frame_ok_n, err_len_n, err_chk_n, err_timeout_n, err_overrun_n;
  logic load_len, store_pay, start_emit, emit_adv;

  // rx_valid is a level; only its rising edge is a new byte
  assign byte_ev   = rx_valid & ~rx_prev;
  assign in_frame  = (state == GET_LEN) || (state == GET_PAY) || (state == GET_CHK);
  assign timed_out = in_frame && !byte_ev && (tmo_cnt == TW'(TIMEOUT_CYCLES));

  assign out_valid = (state == EMIT);
  assign out_data  = out_valid ? buf_mem[rd_idx[IW-1:0]] : 8'd0;
  assign out_last  = out_valid && (rd_idx == len - 8'd1);

  always_comb begin
    state_n       = state;
    frame_ok_n    = 1'b0;
    err_len_n     = 1'b0;
    err_chk_n     = 1'b0;
    err_timeout_n = 1'b0;
    err_overrun_n = 1'b0;
    load_len      = 1'b0;
    store_pay     = 1'b0;
    start_emit    = 1'b0;
    emit_adv      = 1'b0;
    case (state)
      HUNT: begin
        if (byte_ev && rx_data == SOF) state_n = GET_LEN;
      end
      GET_LEN: begin
        if (byte_ev) begin
          if (rx_data == 8'd0 || {24'd0, rx_data} > 32'(MAX_LEN)) begin
            err_len_n = 1'b1;
            state_n   = HUNT;
          end else begin
            load_len = 1'b1;
            state_n  = GET_PAY;
          end
        end else if (timed_out) begin
          err_timeout_n = 1'b1;
          state_n       = HUNT;
        end
      end
      GET_PAY: begin
        if (byte_ev) begin
          store_pay = 1'b1;
          if (idx == len - 8'd1) state_n = GET_CHK;
        end else if (timed_out) begin
          err_timeout_n = 1'b1;
          state_n       = HUNT;
        end
      end
      GET_CHK: begin
        if (byte_ev) begin
          if (rx_data == acc) begin
            frame_ok_n = 1'b1;
            start_emit = 1'b1;
            state_n    = EMIT;
          end else begin
            err_chk_n = 1'b1;
            state_n   = HUNT;
          end
        end else if (timed_out) begin
          err_timeout_n = 1'b1;
          state_n       = HUNT;
        end
      end
      EMIT: begin
        // Incoming bytes cannot be buffered while replaying, so they are dropped
        err_overrun_n = byte_ev;
        emit_adv      = out_ready;
        if (out_ready && out_last) state_n = HUNT;
      end
      default: state_n = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= HUNT;
      rx_prev     <= 1'b1;
      frame_ok    <= 1'b0;
      err_len     <= 1'b0;
      err_chk     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      len         <= 8'd0;
      idx         <= 8'd0;
      rd_idx      <= 8'd0;
      acc         <= 8'd0;
      tmo_cnt     <= '0;
    end else begin
      state       <= state_n;
      rx_prev     <= rx_valid;
      frame_ok    <= frame_ok_n;
      err_len     <= err_len_n;
      err_chk     <= err_chk_n;
      err_timeout <= err_timeout_n;
      err_overrun <= err_overrun_n;
      if (load_len) begin
        len <= rx_data;
        acc <= rx_data;
        idx <= 8'd0;
      end
      if (store_pay) begin
        acc <= acc ^ rx_data;
        idx <= idx + 8'd1;
      end
      if (start_emit) rd_idx <= 8'd0;
      if (emit_adv)   rd_idx <= rd_idx + 8'd1;
      if (!in_frame || byte_ev || state_n != state) tmo_cnt <= '0;
      else                                          tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (store_pay) buf_mem[idx[IW-1:0]] <= rx_data;
  end

endmodule
